// File: rtl/sram_addr_gen.sv
// sram_addr_gen: burst address generator for the SRAM address pins.
// Captures a start address, steps it per access, counts and flags wrap.
module sram_addr_gen #(
    parameter int ADDR_WIDTH = 21,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  avr_clk,
    input  logic                  avr_reset,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic [CNT_WIDTH-1:0]  burst_len,
    input  logic [1:0]            mode,
    input  logic                  access_done,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic                  busy,
    output logic                  burst_done,
    output logic                  wrapped
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONES = '1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = CNT_WIDTH'(1);

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH-1:0] addr_next;
    logic [CNT_WIDTH-1:0]  remaining;
    logic [CNT_WIDTH-1:0]  remaining_next;
    logic                  done_next;
    logic                  wrapped_next;

    // State and datapath registers; every output comes straight from here.
    always_ff @(posedge avr_clk or posedge avr_reset) begin
        if (avr_reset) begin
            state      <= IDLE;
            addr       <= '0;
            remaining  <= '0;
            burst_done <= 1'b0;
            wrapped    <= 1'b0;
        end else begin
            state      <= state_next;
            addr       <= addr_next;
            remaining  <= remaining_next;
            burst_done <= done_next;
            wrapped    <= wrapped_next;
        end
    end

    // Next-state logic: load beats a coincident access; accesses only count in RUN.
    always_comb begin
        state_next     = state;
        addr_next      = addr;
        remaining_next = remaining;
        done_next      = 1'b0;
        wrapped_next   = wrapped;
        if (load) begin
            addr_next      = addr_in;
            remaining_next = burst_len;
            wrapped_next   = 1'b0;
            state_next     = RUN;
        end else if (state == RUN && access_done) begin
            unique case (mode)
                2'b01: begin
                    addr_next = addr + ADDR_ONE;
                    if (addr == ADDR_ONES) begin
                        wrapped_next = 1'b1;
                    end
                end
                2'b10: begin
                    addr_next = addr - ADDR_ONE;
                    if (addr == '0) begin
                        wrapped_next = 1'b1;
                    end
                end
                default: begin
                    addr_next = addr;
                end
            endcase
            if (remaining == CNT_ONE) begin
                remaining_next = '0;
                done_next      = 1'b1;
                state_next     = IDLE;
            end else if (remaining != '0) begin
                remaining_next = remaining - CNT_ONE;
            end
        end
    end

    assign sram_addr = addr;
    assign busy      = (state == RUN);

endmodule

// File: tb/tb_sram_addr_gen.sv
// tb_sram_addr_gen: table-driven vectors plus hand sequences for
// reset mid-burst, unlimited bursts and load/access collisions.
module tb_sram_addr_gen;

    localparam int AW = 21;
    localparam int CW = 8;

    logic          avr_clk;
    logic          avr_reset;
    logic          load;
    logic [AW-1:0] addr_in;
    logic [CW-1:0] burst_len;
    logic [1:0]    mode;
    logic          access_done;
    logic [AW-1:0] sram_addr;
    logic          busy;
    logic          burst_done;
    logic          wrapped;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic          ld;
        logic [AW-1:0] a_in;
        logic [CW-1:0] len;
        logic [1:0]    md;
        logic          ad;
        logic [AW-1:0] e_addr;
        logic          e_busy;
        logic          e_done;
        logic          e_wrap;
    } vec_t;

    vec_t vecs[$];

    sram_addr_gen #(
        .ADDR_WIDTH(AW),
        .CNT_WIDTH (CW)
    ) dut (
        .avr_clk    (avr_clk),
        .avr_reset  (avr_reset),
        .load       (load),
        .addr_in    (addr_in),
        .burst_len  (burst_len),
        .mode       (mode),
        .access_done(access_done),
        .sram_addr  (sram_addr),
        .busy       (busy),
        .burst_done (burst_done),
        .wrapped    (wrapped)
    );

    initial avr_clk = 1'b0;
    always #5 avr_clk = ~avr_clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [AW-1:0] ea,
                           input logic eb, input logic ed, input logic ew);
        chk({tag, " sram_addr"}, int'(sram_addr), int'(ea));
        chk({tag, " busy"}, int'(busy), int'(eb));
        chk({tag, " burst_done"}, int'(burst_done), int'(ed));
        chk({tag, " wrapped"}, int'(wrapped), int'(ew));
    endtask

    // Drive one cycle of inputs, clock it in, then sample 1 time unit later.
    task automatic cyc(input logic ld, input logic [AW-1:0] a,
                       input logic [CW-1:0] len, input logic [1:0] md,
                       input logic ad);
        load        = ld;
        addr_in     = a;
        burst_len   = len;
        mode        = md;
        access_done = ad;
        @(posedge avr_clk);
        #1;
        load        = 1'b0;
        access_done = 1'b0;
    endtask

    function automatic vec_t mk(input logic ld, input logic [AW-1:0] a,
                                input logic [CW-1:0] len, input logic [1:0] md,
                                input logic ad, input logic [AW-1:0] ea,
                                input logic eb, input logic ed, input logic ew);
        vec_t v;
        v.ld = ld; v.a_in = a; v.len = len; v.md = md; v.ad = ad;
        v.e_addr = ea; v.e_busy = eb; v.e_done = ed; v.e_wrap = ew;
        return v;
    endfunction

    initial begin
        logic saw_done;
        avr_reset   = 1'b1;
        load        = 1'b0;
        addr_in     = '0;
        burst_len   = '0;
        mode        = 2'b00;
        access_done = 1'b0;

        // Increment burst of 3, then an ignored pulse in IDLE
        vecs.push_back(mk(1, 21'h012345, 3, 2'b01, 0, 21'h012345, 1, 0, 0));
        vecs.push_back(mk(0, 21'h0,      0, 2'b01, 1, 21'h012346, 1, 0, 0));
        vecs.push_back(mk(0, 21'h0,      0, 2'b01, 1, 21'h012347, 1, 0, 0));
        vecs.push_back(mk(0, 21'h0,      0, 2'b01, 1, 21'h012348, 0, 1, 0));
        vecs.push_back(mk(0, 21'h0,      0, 2'b01, 1, 21'h012348, 0, 0, 0));
        // Increment wrap
        vecs.push_back(mk(1, 21'h1FFFFF, 2, 2'b01, 0, 21'h1FFFFF, 1, 0, 0));
        vecs.push_back(mk(0, 21'h0,      0, 2'b01, 1, 21'h000000, 1, 0, 1));
        vecs.push_back(mk(0, 21'h0,      0, 2'b01, 1, 21'h000001, 0, 1, 1));
        vecs.push_back(mk(0, 21'h0,      0, 2'b01, 0, 21'h000001, 0, 0, 1));
        // Decrement wrap, single access
        vecs.push_back(mk(1, 21'h000000, 1, 2'b10, 0, 21'h000000, 1, 0, 0));
        vecs.push_back(mk(0, 21'h0,      0, 2'b10, 1, 21'h1FFFFF, 0, 1, 1));
        // Hold modes still count accesses
        vecs.push_back(mk(1, 21'h000040, 2, 2'b00, 0, 21'h000040, 1, 0, 0));
        vecs.push_back(mk(0, 21'h0,      0, 2'b00, 1, 21'h000040, 1, 0, 0));
        vecs.push_back(mk(0, 21'h0,      0, 2'b11, 1, 21'h000040, 0, 1, 0));
        // Back-to-back loads, then a plain decrement
        vecs.push_back(mk(1, 21'h000200, 4, 2'b10, 0, 21'h000200, 1, 0, 0));
        vecs.push_back(mk(1, 21'h000100, 0, 2'b10, 0, 21'h000100, 1, 0, 0));
        vecs.push_back(mk(0, 21'h0,      0, 2'b10, 1, 21'h0000FF, 1, 0, 0));

        // Reset state
        #12;
        chk_all("reset", 21'h0, 0, 0, 0);
        @(negedge avr_clk);
        avr_reset = 1'b0;
        @(posedge avr_clk);
        #1;

        foreach (vecs[i]) begin
            cyc(vecs[i].ld, vecs[i].a_in, vecs[i].len, vecs[i].md, vecs[i].ad);
            chk_all($sformatf("vec%0d", i), vecs[i].e_addr, vecs[i].e_busy,
                    vecs[i].e_done, vecs[i].e_wrap);
        end

        // Reset mid-burst acts immediately, without a clock edge
        cyc(1, 21'h012345, 5, 2'b01, 0);
        cyc(0, 21'h0, 0, 2'b01, 1);
        chk_all("pre_reset", 21'h012346, 1, 0, 0);
        #2;
        avr_reset = 1'b1;
        #1;
        chk_all("async_reset", 21'h0, 0, 0, 0);
        @(negedge avr_clk);
        avr_reset = 1'b0;
        #1;
        cyc(0, 21'h0, 0, 2'b01, 1);
        cyc(0, 21'h0, 0, 2'b01, 1);
        chk_all("post_reset", 21'h0, 0, 0, 0);

        // Unlimited burst: 300 consecutive accesses
        cyc(1, 21'h000010, 0, 2'b01, 0);
        saw_done = 1'b0;
        for (int i = 0; i < 300; i++) begin
            cyc(0, 21'h0, 0, 2'b01, 1);
            if (burst_done) saw_done = 1'b1;
        end
        chk("unlimited no burst_done", int'(saw_done), 0);
        chk_all("unlimited", 21'h00013C, 1, 0, 0);

        // Load collides with access_done: load wins
        cyc(1, 21'h000100, 3, 2'b01, 1);
        chk_all("collision", 21'h000100, 1, 0, 0);
        cyc(0, 21'h0, 0, 2'b01, 1);
        cyc(0, 21'h0, 0, 2'b01, 1);
        cyc(0, 21'h0, 0, 2'b01, 1);
        chk_all("collision_count", 21'h000103, 0, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_addr_gen.md
# sram_addr_gen

Burst address generator between the serial address shift register and the SRAM address pins. It captures a parallel start address from the shift register and drives `sram_addr`. After each completed SRAM access reported by the bus FSM, it steps the address up or down, so the AVR can stream a block of bytes without re-shifting an address for every byte. It also counts the accesses in a burst, signals burst completion, and flags address wrap-around.

## Interface
- `ADDR_WIDTH`, 21, width of SRAM address and of `addr_in`
- `CNT_WIDTH`, 8, width of burst length counter

- `avr_clk`  in  1  system clock, all state on rising edge
- `avr_reset`  in  1  asynchronous, active-high reset
- `load`  in  1  one-cycle strobe: capture `addr_in` and `burst_len`, start burst
- `addr_in`  in  ADDR_WIDTH  parallel start address from shift register
- `burst_len`  in  CNT_WIDTH  accesses in burst; 0 = unlimited
- `mode`  in  2  step mode from `avr_ctrl[1:0]`: 00 hold, 01 increment, 10 decrement, 11 hold
- `access_done`  in  1  one-cycle pulse from bus FSM at end of each SRAM access
- `sram_addr`  out  ADDR_WIDTH  registered SRAM address
- `busy`  out  1  high while a burst is active
- `burst_done`  out  1  one-cycle pulse when the final access of a finite burst completes
- `wrapped`  out  1  sticky wrap flag; cleared by `load`

## Operation
- Two states: IDLE and RUN. Internal registers: `addr` (drives `sram_addr`) and `remaining` (CNT_WIDTH).
- Reset values: state IDLE, `sram_addr` 0, `remaining` 0, `busy` 0, `burst_done` 0, `wrapped` 0.
- `load` is honoured in any state:
  - `addr` ← `addr_in`, `remaining` ← `burst_len`, `wrapped` ← 0, state ← RUN.
- IDLE:
  - `access_done` is ignored; address and flags hold.
  - `busy` = 0.
- RUN, `busy` = 1. On `access_done` without `load`:
  - Address step by `mode` sampled that cycle: 01 → `addr`+1 mod 2^ADDR_WIDTH; 10 → `addr`−1 mod 2^ADDR_WIDTH; 00/11 → unchanged.
  - Increment from all-ones to 0, or decrement from 0 to all-ones, sets `wrapped` to 1. `wrapped` stays set until the next `load` or reset.
  - Hold modes still count the access.
  - If `remaining` = 0 (unlimited burst): no decrement; state stays RUN until the next `load` or reset.
  - If `remaining` > 1: `remaining` decrements; state stays RUN.
  - If `remaining` = 1: `remaining` ← 0, `burst_done` pulses, state ← IDLE.
- Simultaneous `load` and `access_done`: `load` wins; the access is neither stepped nor counted.
- `burst_done` is high for exactly one cycle per finite burst and never fires for unlimited bursts.
- Reset asserted mid-burst: all registers go to their reset values immediately (asynchronously). Operation restarts only on a new `load` after reset is released.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- `load` at edge N: from edge N onward, `sram_addr` = `addr_in`, `busy` = 1, `wrapped` = 0.
- `access_done` at edge N: the stepped `sram_addr` appears after edge N, i.e. one-cycle latency.
- On the final access of a finite burst (edge N), the following change together, valid in cycle N+1:
  - `sram_addr` takes its stepped value.
  - `burst_done` = 1.
  - `busy` = 0.
- `burst_done` returns to 0 at edge N+1.
- `access_done` may be asserted on consecutive cycles; each pulse is one access.
- `load` is accepted at full rate, every cycle if driven so.
- `mode` needs to be valid only in cycles where `access_done` is high.

## Test plan
- Reset mid-burst: load 0x012345, `burst_len` 5, `mode` 01, one `access_done`, then assert `avr_reset` → `sram_addr` 0x000000, `busy` 0, `wrapped` 0 immediately; further `access_done` pulses have no effect.
- Increment burst: load 0x012345, `burst_len` 3, `mode` 01, three `access_done` pulses → `sram_addr` 0x012346, 0x012347, 0x012348; `burst_done` high exactly one cycle after the third pulse; `busy` 0 afterwards; a fourth pulse leaves 0x012348.
- Increment wrap: load 0x1FFFFF, `burst_len` 2, `mode` 01, two pulses → 0x000000 with `wrapped` 1, then 0x000001 with `burst_done`; `wrapped` stays 1 until the next `load`.
- Decrement wrap, hold mode: load 0x000000, `burst_len` 1, `mode` 10, one pulse → 0x1FFFFF, `wrapped` 1, `burst_done`. Then load 0x000040, `burst_len` 2, `mode` 00, two pulses → address stays 0x000040, `burst_done` after the second pulse.
- Unlimited burst and collision: load 0x000010, `burst_len` 0, `mode` 01, 300 pulses → 0x00013C, `busy` 1, no `burst_done`. Then `load` 0x000100 in the same cycle as `access_done` → `sram_addr` 0x000100, no step, `wrapped` 0, `busy` 1.
